// File: rtl/int_pkg.sv
// Shared constants for the interrupt controller: FSM state encoding and register map.
package int_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_EOI  = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

endpackage

// File: rtl/prio_enc.sv
// Combinational priority encoder: the lowest set index wins (index 0 is highest priority).
module prio_enc #(
  parameter int unsigned NSRC = 8,
  parameter int unsigned IDW  = 3
) (
  input  logic [NSRC-1:0] req_i,
  output logic [IDW-1:0]  id_o,
  output logic            valid_o
);

  // Scan from the top down so the last (lowest) hit overrides.
  always_comb begin
    id_o = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = IDW'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/int_ctrl.sv
// Priority interrupt controller: edge-triggered pending bits, mask, Intr/Inta handshake
// and EOI-terminated service, with a small memory-mapped register port.
module int_ctrl
  import int_pkg::*;
#(
  parameter int unsigned     NSRC     = 8,
  parameter int unsigned     IDW      = 3,
  parameter logic [NSRC-1:0] MASK_RST = '0
) (
  input  logic            Clk,
  input  logic            Clrn,
  input  logic [NSRC-1:0] Irq,
  input  logic            Inta,
  input  logic            We,
  input  logic [1:0]      Addr,
  input  logic [31:0]     Wdata,
  output logic [31:0]     Rdata,
  output logic            Intr,
  output logic [IDW-1:0]  Vector
);

  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] irq_prev_q;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] rise, req, w1c;
  logic [1:0]      state_q, state_d;
  logic            intr_q, intr_d;
  logic [IDW-1:0]  vector_q, vector_d;
  logic [IDW-1:0]  win_id;
  logic            win_valid;
  logic            eoi_wr;
  logic            unused_wdata;

  assign unused_wdata = ^Wdata;

  assign rise   = Irq & ~irq_prev_q;
  assign req    = pending_q & mask_q;
  assign w1c    = (We && Addr == A_PEND) ? Wdata[NSRC-1:0] : '0;
  assign eoi_wr = We && (Addr == A_EOI);

  prio_enc #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) u_prio_enc (
    .req_i   (req),
    .id_o    (win_id),
    .valid_o (win_valid)
  );

  // Set beats W1C; acknowledge of the latched source beats set.
  always_comb begin
    pending_d = (pending_q & ~w1c) | rise;
    if (state_q == ST_REQ && Inta) pending_d[vector_q] = 1'b0;
    mask_d = (We && Addr == A_MASK) ? Wdata[NSRC-1:0] : mask_q;
  end

  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d  = ST_REQ;
          vector_d = win_id;
        end
      end
      ST_REQ:     if (Inta) state_d = ST_SERVICE;
      ST_SERVICE: if (eoi_wr) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    intr_d = (state_d == ST_REQ);
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      pending_q  <= '0;
      irq_prev_q <= '0;
      mask_q     <= MASK_RST;
      state_q    <= ST_IDLE;
      intr_q     <= 1'b0;
      vector_q   <= '0;
    end else begin
      pending_q  <= pending_d;
      irq_prev_q <= Irq;
      mask_q     <= mask_d;
      state_q    <= state_d;
      intr_q     <= intr_d;
      vector_q   <= vector_d;
    end
  end

  assign Intr   = intr_q;
  assign Vector = vector_q;

  always_comb begin
    Rdata = '0;
    unique case (Addr)
      A_PEND: Rdata[NSRC-1:0] = pending_q;
      A_MASK: Rdata[NSRC-1:0] = mask_q;
      A_EOI:  Rdata = '0;
      A_STAT: begin
        Rdata[17:16]    = state_q;
        Rdata[IDW-1:0]  = vector_q;
      end
      default: Rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed handshake scenarios and random traffic, every cycle
// checked against a behavioural model of the controller.
module tb_int_ctrl;

  localparam int NSRC = 8;
  localparam int IDW  = 3;

  logic            Clk;
  logic            Clrn;
  logic [NSRC-1:0] Irq;
  logic            Inta;
  logic            We;
  logic [1:0]      Addr;
  logic [31:0]     Wdata;
  logic [31:0]     Rdata;
  logic            Intr;
  logic [IDW-1:0]  Vector;

  int n_cmp = 0;
  int n_bad = 0;

  int_ctrl #(
    .NSRC     (NSRC),
    .IDW      (IDW),
    .MASK_RST (8'h00)
  ) dut (
    .Clk    (Clk),
    .Clrn   (Clrn),
    .Irq    (Irq),
    .Inta   (Inta),
    .We     (We),
    .Addr   (Addr),
    .Wdata  (Wdata),
    .Rdata  (Rdata),
    .Intr   (Intr),
    .Vector (Vector)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural model: stage 0 idle, 1 waiting for acknowledge, 2 in service.
  logic [NSRC-1:0] m_pend, m_prev, m_mask;
  int              m_stage;
  int              m_vec;

  always @(posedge Clk or negedge Clrn) begin : model
    logic [NSRC-1:0] p;
    logic [NSRC-1:0] enabled;
    int              winner;
    if (!Clrn) begin
      m_pend  <= '0;
      m_prev  <= '0;
      m_mask  <= '0;
      m_stage <= 0;
      m_vec   <= 0;
    end else begin
      p = m_pend;
      if (We && Addr == 2'd0) p = p & ~Wdata[NSRC-1:0];
      p = p | (Irq & ~m_prev);
      if (m_stage == 1 && Inta) p[m_vec] = 1'b0;
      m_pend <= p;
      m_prev <= Irq;
      if (We && Addr == 2'd1) m_mask <= Wdata[NSRC-1:0];
      enabled = m_pend & m_mask;
      winner  = -1;
      for (int i = NSRC - 1; i >= 0; i--) if (enabled[i]) winner = i;
      if (m_stage == 0 && winner >= 0) begin
        m_stage <= 1;
        m_vec   <= winner;
      end else if (m_stage == 1 && Inta) begin
        m_stage <= 2;
      end else if (m_stage == 2 && We && Addr == 2'd2) begin
        m_stage <= 0;
      end
    end
  end

  function automatic logic [31:0] model_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_pend);
      2'd1:    return 32'(m_mask);
      2'd3:    return (32'(m_stage) << 16) | 32'(m_vec);
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Clrn) begin
      chk("model_intr", 32'(Intr), 32'(m_stage == 1));
      chk("model_vector", 32'(Vector), 32'(m_vec));
      chk("model_rdata", Rdata, model_rdata(Addr));
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    We = 1'b1;
    Addr = a;
    Wdata = d;
    cyc();
    We = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input string nm, input logic [31:0] exp);
    Addr = a;
    #1;
    chk(nm, Rdata, exp);
  endtask

  task automatic ack();
    Inta = 1'b1;
    cyc();
    Inta = 1'b0;
  endtask

  initial begin
    Clrn = 1'b0;
    Irq = '0;
    Inta = 1'b0;
    We = 1'b0;
    Addr = 2'd0;
    Wdata = '0;
    repeat (3) cyc();
    Clrn = 1'b1;
    cyc();

    // Basic handshake on source 5.
    wr(2'd1, 32'hFF);
    Irq[5] = 1'b1;
    cyc();
    rd(2'd0, "hs_pend", 32'h20);
    chk("hs_intr_early", 32'(Intr), 32'd0);
    cyc();
    chk("hs_intr", 32'(Intr), 32'd1);
    chk("hs_vec", 32'(Vector), 32'd5);
    cyc();
    ack();
    chk("hs_intr_ack", 32'(Intr), 32'd0);
    rd(2'd0, "hs_pend_ack", 32'h00);
    rd(2'd3, "hs_stat_svc", 32'h0002_0005);
    wr(2'd2, 32'h0);
    rd(2'd3, "hs_stat_idle", 32'h0000_0005);
    Irq = '0;
    cyc();

    // Priority and freeze.
    Irq = 8'h44;
    cyc();
    cyc();
    chk("pr_vec2", 32'(Vector), 32'd2);
    Irq = 8'h45;
    cyc();
    cyc();
    chk("pr_frozen", 32'(Vector), 32'd2);
    chk("pr_intr", 32'(Intr), 32'd1);
    ack();
    wr(2'd2, 32'h0);
    cyc();
    chk("pr_vec0", 32'(Vector), 32'd0);
    chk("pr_reassert", 32'(Intr), 32'd1);
    ack();
    wr(2'd2, 32'h0);
    cyc();
    chk("pr_vec6", 32'(Vector), 32'd6);
    ack();
    wr(2'd2, 32'h0);
    Irq = '0;
    cyc();

    // Masking.
    wr(2'd1, 32'h00);
    Irq[3] = 1'b1;
    cyc();
    cyc();
    rd(2'd0, "mk_pend", 32'h08);
    chk("mk_intr_off", 32'(Intr), 32'd0);
    wr(2'd1, 32'h08);
    chk("mk_intr_wait", 32'(Intr), 32'd0);
    cyc();
    chk("mk_intr_on", 32'(Intr), 32'd1);
    chk("mk_vec", 32'(Vector), 32'd3);
    ack();
    wr(2'd2, 32'h0);
    Irq = '0;

    // Rise and W1C on the same bit: set wins; a held level does not re-pend.
    Irq[4] = 1'b1;
    wr(2'd0, 32'h10);
    rd(2'd0, "w1c_setwins", 32'h10);
    wr(2'd0, 32'h10);
    repeat (10) cyc();
    rd(2'd0, "level_no_repend", 32'h00);
    Irq = '0;

    // Acknowledge clears the latched bit despite a same-cycle rise.
    wr(2'd1, 32'hFF);
    Irq[1] = 1'b1;
    cyc();
    cyc();
    Irq = '0;
    cyc();
    Irq[1] = 1'b1;
    ack();
    rd(2'd0, "ack_beats_rise", 32'h00);
    wr(2'd2, 32'h0);
    Irq = '0;
    cyc();

    // Ignored events.
    ack();
    rd(2'd3, "inta_idle", 32'h0000_0001);
    Irq[7] = 1'b1;
    cyc();
    cyc();
    wr(2'd2, 32'h0);
    chk("eoi_in_req", 32'(Intr), 32'd1);
    ack();
    Irq[6] = 1'b1;
    cyc();
    cyc();
    rd(2'd0, "svc_pend", 32'h40);
    chk("svc_intr", 32'(Intr), 32'd0);
    wr(2'd2, 32'h0);
    cyc();
    chk("post_eoi_intr", 32'(Intr), 32'd1);
    chk("post_eoi_vec", 32'(Vector), 32'd6);

    // Asynchronous reset while requesting.
    Clrn = 1'b0;
    #1;
    chk("rst_intr", 32'(Intr), 32'd0);
    chk("rst_vec", 32'(Vector), 32'd0);
    rd(2'd0, "rst_pend", 32'h00);
    rd(2'd1, "rst_mask", 32'h00);
    Irq = '0;
    cyc();
    Clrn = 1'b1;
    cyc();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NSRC; b++) if ($urandom_range(7) == 0) Irq[b] = ~Irq[b];
      Inta  = !Inta && ($urandom_range(4) == 0);
      We    = ($urandom_range(5) == 0);
      Addr  = 2'($urandom_range(3));
      Wdata = $urandom;
      if (We && Addr == 2'd1 && $urandom_range(1) == 1) Wdata[7:0] = 8'hFF;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
